// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready handshake on both
// sides, a single-entry result register and an architectural CC register.
// Modes: 0 add, 1 sub, 2 and, 3 xor, 4 shl, 5 sar, 6 mul, 7 reserved.
// Optional feature macro: ALU_MUL_EN. When defined, mode 6 is a signed
// multiply (low WIDTH bits) computed by an iterative shift-add unit over
// WIDTH cycles. When undefined, the multiplier is not built and mode 6 is
// reported as an illegal op.
module alu_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flags,
    output logic [2:0]       cc,
    output logic             op_err
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_SHL = 3'd4,
        OP_SAR = 3'd5,
        OP_MUL = 3'd6,
        OP_RSV = 3'd7
    } op_e;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        MUL  = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q;
    logic [2:0]       flags_q;
    logic [2:0]       cc_q;
    logic             op_err_q;

    logic             accept;
    logic             load_alu;
    op_e              op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_of;
    logic             alu_err;
    logic [2:0]       alu_flags;
    logic [SHW-1:0]   shamt;

    assign op        = op_e'(mode);
    assign shamt     = b[SHW-1:0];
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == HOLD);
    assign out       = out_q;
    assign flags     = flags_q;
    assign cc        = cc_q;
    assign op_err    = op_err_q;

`ifdef ALU_MUL_EN
    logic             is_mul;
    logic             start_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_acc_q;
    logic [WIDTH-1:0] mul_mcand_q;
    logic [WIDTH-1:0] mul_mplier_q;
    logic [SHW-1:0]   mul_cnt_q;
    logic             mul_cc_q;
    logic [WIDTH-1:0] mul_sum;
    logic [2:0]       mul_flags;

    assign is_mul    = (op == OP_MUL);
    assign start_mul = accept & is_mul;
    assign mul_sum   = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
    // The last step's sum goes straight into the result register.
    assign mul_done  = (state_q == MUL) && (mul_cnt_q == SHW'(WIDTH - 1));
    assign mul_flags = {(mul_sum == '0), mul_sum[WIDTH-1], 1'b0};
    assign load_alu  = accept & ~is_mul;
`else
    assign load_alu  = accept;
`endif

    // Handshake on the input side: ready in IDLE, or in HOLD when the held result leaves.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        in_ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE:    in_ready = 1'b1;
                HOLD:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Single-cycle datapath: result, overflow and illegal-op detection from the live inputs.
    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        alu_err = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = a + b;
                alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: alu_res = a << shamt;
            OP_SAR: alu_res = $signed(a) >>> shamt;
`ifdef ALU_MUL_EN
            // Handled by the iterative unit; this path is not loaded for mul.
            OP_MUL: alu_res = '0;
`endif
            default: alu_err = 1'b1;
        endcase
        // An illegal op leaves alu_res at zero, so ZF=1, SF=0, OF=0 falls out naturally.
        alu_flags = {(alu_res == '0), alu_res[WIDTH-1], alu_of};
    end

    // Next-state logic for IDLE / MUL / HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    state_d = is_mul ? MUL : HOLD;
`else
                    state_d = HOLD;
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) begin
`ifdef ALU_MUL_EN
                        state_d = is_mul ? MUL : HOLD;
`else
                        state_d = HOLD;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                if (mul_done) state_d = HOLD;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, result register and architectural CC register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            flags_q  <= '0;
            op_err_q <= 1'b0;
            cc_q     <= 3'b100;
        end else begin
            state_q <= state_d;
            if (load_alu) begin
                out_q    <= alu_res;
                flags_q  <= alu_flags;
                op_err_q <= alu_err;
                if (set_cc && !alu_err) cc_q <= alu_flags;
            end
`ifdef ALU_MUL_EN
            if (mul_done) begin
                out_q    <= mul_sum;
                flags_q  <= mul_flags;
                op_err_q <= 1'b0;
                if (mul_cc_q) cc_q <= mul_flags;
            end
`endif
        end
    end

`ifdef ALU_MUL_EN
    // Shift-add multiplier: one partial product per cycle while in MUL.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are not reset; they are always initialised at accept and only observed via state_q.
        if (start_mul) begin
            mul_acc_q    <= '0;
            mul_mcand_q  <= a;
            mul_mplier_q <= b;
            mul_cnt_q    <= '0;
            mul_cc_q     <= set_cc;
        end else if (state_q == MUL) begin
            mul_acc_q    <= mul_sum;
            mul_mcand_q  <= {mul_mcand_q[WIDTH-2:0], 1'b0};
            mul_mplier_q <= {1'b0, mul_mplier_q[WIDTH-1:1]};
            mul_cnt_q    <= mul_cnt_q + SHW'(1);
        end
    end
`endif

endmodule
